// File: rtl/ddr2_ex_lfsr_gen_chk.sv
// Galois LFSR write-data generator plus self-synchronising read-data checker for DDR2 example traffic.
// Define DDR2_EX_LFSR_ERR_INJ_EN to add err_inj, which flips bit0 of one generated word without disturbing the LFSR.
module ddr2_ex_lfsr_gen_chk #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] POLY      = WIDTH'('h1D),
  parameter logic [31:0]      SEED      = 32'd32,
  parameter int               STEPS     = 1,
  parameter int               LOCK_CNT  = 4,
  parameter int               MISS_MAX  = 8,
  parameter int               ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 pause,
  input  logic                 load,
  input  logic [WIDTH-1:0]     ldata,
`ifdef DDR2_EX_LFSR_ERR_INJ_EN
  input  logic                 err_inj,
`endif
  output logic [WIDTH-1:0]     data,
  input  logic                 chk_valid,
  input  logic [WIDTH-1:0]     chk_data,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];
  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam int MS_W = $clog2(MISS_MAX + 1);
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(LOCK_CNT - 1);
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(MISS_MAX - 1);

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] v;
    v = x;
    for (int i = 0; i < STEPS; i++)
      v = {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
    return v;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
    return (&c) ? c : c + ERR_CNT_W'(1);
  endfunction

  // Generator stage
  logic [WIDTH-1:0] lfsr_p0;
  logic [WIDTH-1:0] lfsr_nxt;

  always_comb begin
    lfsr_nxt = lfsr_p0;
    if (!enable)
      lfsr_nxt = SEED_W;
    else if (load)
      lfsr_nxt = (ldata == '0) ? SEED_W : ldata;
    else if (!pause)
      lfsr_nxt = advance(lfsr_p0);
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_p0 <= SEED_W;
    else       lfsr_p0 <= lfsr_nxt;
  end

`ifdef DDR2_EX_LFSR_ERR_INJ_EN
  logic [WIDTH-1:0] data_p0;
  logic             gen_adv;
  assign gen_adv = enable && !load && !pause;

  // The corrupted word lives only in the output register; a pause keeps showing it.
  always_ff @(posedge clk) begin
    if (reset)
      data_p0 <= SEED_W;
    else if (gen_adv && err_inj)
      data_p0 <= lfsr_nxt ^ WIDTH'(1);
    else if (gen_adv || !enable || load)
      data_p0 <= lfsr_nxt;
  end
  assign data = data_p0;
`else
  assign data = lfsr_p0;
`endif

  // Checker stage
  typedef enum logic [1:0] {ST_IDLE, ST_SEED, ST_LOCKING, ST_LOCKED} state_t;
  state_t           state_p0, state_nxt;
  logic [WIDTH-1:0] ref_p0;
  logic [MC_W-1:0]  mcnt_p0;
  logic [MS_W-1:0]  miss_p0;
  logic             match;
  logic             ref_seed, ref_step, mcnt_inc, cnt_clr, miss_inc, err_set;

  assign match = (chk_data == ref_p0);

  always_ff @(posedge clk) begin
    if (reset) state_p0 <= ST_IDLE;
    else       state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    if (!enable)
      state_nxt = ST_IDLE;
    else begin
      case (state_p0)
        ST_IDLE:    state_nxt = ST_SEED;
        ST_SEED:    if (chk_valid) state_nxt = ST_LOCKING;
        ST_LOCKING: if (chk_valid && match && mcnt_p0 == MC_LAST) state_nxt = ST_LOCKED;
        ST_LOCKED:  if (chk_valid && !match && miss_p0 == MS_LAST) state_nxt = ST_SEED;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ref_seed = 1'b0;
    ref_step = 1'b0;
    mcnt_inc = 1'b0;
    cnt_clr  = 1'b0;
    miss_inc = 1'b0;
    err_set  = 1'b0;
    if (!enable)
      cnt_clr = 1'b1;
    else if (chk_valid) begin
      case (state_p0)
        ST_SEED: begin
          ref_seed = 1'b1;
          cnt_clr  = 1'b1;
        end
        ST_LOCKING: begin
          if (match) begin
            ref_step = 1'b1;
            mcnt_inc = 1'b1;
          end else begin
            ref_seed = 1'b1;
            cnt_clr  = 1'b1;
          end
        end
        ST_LOCKED: begin
          ref_step = 1'b1;
          if (match) cnt_clr = 1'b1;
          else begin
            err_set  = 1'b1;
            miss_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Miss count is only meaningful while staying in LOCKED, so any exit clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_p0  <= SEED_W;
      mcnt_p0 <= '0;
      miss_p0 <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
      locked  <= 1'b0;
    end else begin
      if (ref_seed)      ref_p0 <= advance(chk_data);
      else if (ref_step) ref_p0 <= advance(ref_p0);
      if (cnt_clr)       mcnt_p0 <= '0;
      else if (mcnt_inc) mcnt_p0 <= mcnt_p0 + MC_W'(1);
      if (cnt_clr || state_nxt != ST_LOCKED) miss_p0 <= '0;
      else if (miss_inc)                     miss_p0 <= miss_p0 + MS_W'(1);
      err <= err_set;
      if (err_set) err_cnt <= sat_inc(err_cnt);
      locked <= (state_nxt == ST_LOCKED);
    end
  end

endmodule

// File: tb/tb_ddr2_ex_lfsr_gen_chk.sv
// Bench for ddr2_ex_lfsr_gen_chk: cycle-by-cycle behavioural model plus hand-computed pins.
module tb_ddr2_ex_lfsr_gen_chk;
  localparam int LOCKN = 4;
  localparam int MISSN = 8;
  localparam int CW    = 4;
  localparam int SEEDV = 32;

  logic       clk = 1'b0;
  logic       reset, enable, pause, load, err_inj, chk_valid;
  logic [7:0] ldata, chk_data, data;
  logic       locked, err;
  logic [CW-1:0] err_cnt;

  always #5 clk = ~clk;

  ddr2_ex_lfsr_gen_chk #(
    .WIDTH(8), .POLY(8'h1D), .SEED(32'd32), .STEPS(1),
    .LOCK_CNT(LOCKN), .MISS_MAX(MISSN), .ERR_CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .pause(pause),
    .load(load),
    .ldata(ldata),
`ifdef DDR2_EX_LFSR_ERR_INJ_EN
    .err_inj(err_inj),
`endif
    .data(data),
    .chk_valid(chk_valid),
    .chk_data(chk_data),
    .locked(locked),
    .err(err),
    .err_cnt(err_cnt)
  );

  function automatic int adv(input int x);
    return ((x * 2) % 256) ^ ((x >= 128) ? 8'h1D : 0);
  endfunction

  // Model: phase 0 idle, 1 waiting for seed word, 2 counting good words, 3 locked
  int m_data, m_lfsr, m_ref, m_phase, m_good, m_bad, m_cnt, m_err, m_locked;
  always @(posedge clk) begin
    if (reset) begin
      m_lfsr = SEEDV; m_data = SEEDV; m_ref = SEEDV; m_phase = 0;
      m_good = 0; m_bad = 0; m_cnt = 0; m_err = 0; m_locked = 0;
    end else begin
      if (!enable) begin
        m_lfsr = SEEDV; m_data = SEEDV;
      end else if (load) begin
        m_lfsr = (ldata == 8'h00) ? SEEDV : int'(ldata);
        m_data = m_lfsr;
      end else if (!pause) begin
        m_lfsr = adv(m_lfsr);
        m_data = err_inj ? (m_lfsr ^ 1) : m_lfsr;
      end
      m_err = 0;
      if (!enable) begin
        m_phase = 0; m_good = 0; m_bad = 0;
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (chk_valid) begin
        if (m_phase == 1) begin
          m_ref = adv(int'(chk_data)); m_good = 0; m_phase = 2;
        end else if (m_phase == 2) begin
          if (int'(chk_data) == m_ref) begin
            m_ref = adv(m_ref); m_good++;
            if (m_good == LOCKN) begin m_phase = 3; m_bad = 0; end
          end else begin
            m_ref = adv(int'(chk_data)); m_good = 0;
          end
        end else begin
          if (int'(chk_data) == m_ref) m_bad = 0;
          else begin
            m_err = 1; m_bad++;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            if (m_bad == MISSN) begin m_phase = 1; m_bad = 0; end
          end
          m_ref = adv(m_ref);
        end
      end
      m_locked = (m_phase == 3) ? 1 : 0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;
  int lit_kind = 0;
  int lit_d, lit_l, lit_e, lit_c;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_data", int'(data), m_data);
      chk("model_locked", int'(locked), m_locked);
      chk("model_err", int'(err), m_err);
      chk("model_err_cnt", int'(err_cnt), m_cnt);
    end
    if (lit_kind == 1 || lit_kind == 3) chk("pin_data", int'(data), lit_d);
    if (lit_kind == 2 || lit_kind == 3) begin
      chk("pin_locked", int'(locked), lit_l);
      chk("pin_err", int'(err), lit_e);
      chk("pin_err_cnt", int'(err_cnt), lit_c);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input int kind, input int d, input int l, input int e, input int c);
    lit_d = d; lit_l = l; lit_e = e; lit_c = c; lit_kind = kind;
    @(negedge clk);
    #1;
    lit_kind = 0;
  endtask

  initial begin
    reset = 1; enable = 0; pause = 0; load = 0; ldata = 0;
    chk_valid = 0; chk_data = 0; err_inj = 0;
    cyc(); cyc();
    cmp_on = 1'b1;
    pin(3, 8'h20, 0, 0, 0);
    reset = 0; enable = 1;
    cyc(); pin(1, 8'h40, 0, 0, 0);
    cyc(); pin(1, 8'h80, 0, 0, 0);
    pause = 1;
    repeat (3) begin cyc(); pin(1, 8'h80, 0, 0, 0); end
    pause = 0;
    cyc(); pin(1, 8'h1D, 0, 0, 0);
    cyc(); pin(1, 8'h3A, 0, 0, 0);
    load = 1; ldata = 8'h00;
    cyc(); pin(1, 8'h20, 0, 0, 0);
    load = 1; pause = 1; ldata = 8'h55;
    cyc(); pin(1, 8'h55, 0, 0, 0);
    load = 0; pause = 0;
    cyc(); pin(1, 8'hAA, 0, 0, 0);
    cyc(); pin(1, 8'h49, 0, 0, 0);

    // Loopback lock: one seed word plus four matches
    chk_valid = 1; chk_data = data;
    for (int i = 1; i <= 5; i++) begin
      cyc(); chk_data = data;
      if (i == 4) pin(2, 0, 0, 0, 0);
      if (i == 5) pin(2, 0, 1, 0, 0);
    end
    repeat (20) begin cyc(); chk_data = data; end

    // Burst of eight wrong words forces resync
    chk_data = data ^ 8'hFF;
    for (int i = 1; i <= 8; i++) begin
      cyc(); chk_data = (i < 8) ? (data ^ 8'hFF) : data;
      if (i == 1) pin(2, 0, 1, 1, 1);
      if (i == 7) pin(2, 0, 1, 1, 7);
      if (i == 8) pin(2, 0, 0, 1, 8);
    end
    for (int i = 1; i <= 5; i++) begin
      cyc(); chk_data = data;
      if (i == 4) pin(2, 0, 0, 0, 8);
      if (i == 5) pin(2, 0, 1, 0, 8);
    end

    // Single flipped word
    chk_data = data ^ 8'h01;
    cyc(); chk_data = data; pin(2, 0, 1, 1, 9);
    cyc(); chk_data = data; pin(2, 0, 1, 0, 9);

    // Second burst drives the 4-bit counter into saturation
    chk_data = data ^ 8'hFF;
    for (int i = 1; i <= 8; i++) begin
      cyc(); chk_data = (i < 8) ? (data ^ 8'hFF) : data;
      if (i == 6) pin(2, 0, 1, 1, 15);
      if (i == 8) pin(2, 0, 0, 1, 15);
    end
    repeat (6) begin cyc(); chk_data = data; end

    // Disable: generator to seed, checker idle, count retained
    enable = 0;
    cyc(); pin(3, 8'h20, 0, 0, 15);
    enable = 1; chk_data = data;
    for (int i = 1; i <= 6; i++) begin
      cyc(); chk_data = data;
      if (i == 5) pin(2, 0, 0, 0, 15);
      if (i == 6) pin(2, 0, 1, 0, 15);
    end

    // Reset mid-stream with a mismatching word pending
    chk_data = data ^ 8'hFF; reset = 1;
    cyc(); pin(3, 8'h20, 0, 0, 0);
    reset = 0; chk_data = data;
    for (int i = 1; i <= 6; i++) begin
      cyc(); chk_data = data;
      if (i == 6) pin(2, 0, 1, 0, 0);
    end
`ifdef DDR2_EX_LFSR_ERR_INJ_EN
    err_inj = 1;
    cyc(); err_inj = 0; chk_data = data;
    cyc(); chk_data = data; pin(2, 0, 1, 1, 1);
    cyc(); chk_data = data; pin(2, 0, 1, 0, 1);
`endif
    repeat (10) begin cyc(); chk_data = data; end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
